// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: drains each character or break, tags it with status
// flags, queues it in a show-ahead FIFO and raises level and character-timeout interrupts.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [8:0]            rxData,
    input  logic                  rxDataReceived,
    input  logic                  rxParityError,
    input  logic                  rxOverflow,
    input  logic                  rxBreak,
    input  logic                  rxSilence,
    output logic                  rxReceiveReq,
    output logic [11:0]           rdData,
    output logic                  rdValid,
    input  logic                  rdPop,
    input  logic                  flush,
    input  logic [DEPTH_LOG2:0]   threshold,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  fifoOverrun,
    input  logic                  clearOverrun,
    output logic                  irqLevel,
    output logic                  irqTimeout
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [11:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  req_q, req_d;
    logic                  overrun_q, overrun_d;
    logic                  armed_q, armed_d;
    logic                  irq_level_q, irq_level_d;
    logic                  irq_timeout_q, irq_timeout_d;

    logic                  empty, full, capture, pop_ok, push_ok, drop;
    logic [11:0]           entry;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        // The receiver still shows the captured flags while the request is high.
        capture = (rxDataReceived | rxBreak) & ~req_q;
        pop_ok  = rdPop & ~empty & ~flush;
        push_ok = capture & ~flush & (~full | pop_ok);
        drop    = capture & ~flush & full & ~pop_ok;

        if (rxDataReceived)
            entry = {rxOverflow, rxBreak, rxParityError, rxData};
        else
            entry = {rxOverflow, 1'b1, 1'b0, 9'd0};

        req_d    = capture;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok)
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop_ok)
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        if (push_ok && !pop_ok)
            count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok)
            count_d = count_q - CW'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // A drop in the same cycle as clearOverrun must leave the flag set.
        if (flush)
            overrun_d = 1'b0;
        else if (drop)
            overrun_d = 1'b1;
        else if (clearOverrun)
            overrun_d = 1'b0;
        else
            overrun_d = overrun_q;

        if (flush)
            armed_d = 1'b0;
        else if (push_ok)
            armed_d = 1'b1;
        else if (pop_ok)
            armed_d = 1'b0;
        else
            armed_d = armed_q;

        irq_timeout_d = armed_q & rxSilence & ~empty;
        irq_level_d   = (threshold != '0) && (count_d >= threshold);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            req_q         <= 1'b0;
            overrun_q     <= 1'b0;
            armed_q       <= 1'b0;
            irq_level_q   <= 1'b0;
            irq_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            req_q         <= req_d;
            overrun_q     <= overrun_d;
            armed_q       <= armed_d;
            irq_level_q   <= irq_level_d;
            irq_timeout_q <= irq_timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= entry;
    end

    assign rdData       = empty ? '0 : mem_q[rd_ptr_q];
    assign rdValid      = ~empty;
    assign count        = count_q;
    assign rxReceiveReq = req_q;
    assign fifoOverrun  = overrun_q;
    assign irqLevel     = irq_level_q;
    assign irqTimeout   = irq_timeout_q;
endmodule
